// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl_pkg
//  Description : Shared definitions for the multi-cycle MIPS controller.
//                Contents: opcode and funct codes, state encodings, ALU
//                operand-B and PC-source select encodings, the packed
//                control-output bundle, and an R-type funct legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_multicycle_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Controller state encoding
    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_FETCH   = 4'd1;
    localparam state_t S_DECODE  = 4'd2;
    localparam state_t S_MEMADR  = 4'd3;
    localparam state_t S_MEMRD   = 4'd4;
    localparam state_t S_MEMWB   = 4'd5;
    localparam state_t S_MEMWR   = 4'd6;
    localparam state_t S_EXEC_R  = 4'd7;
    localparam state_t S_ALUWB   = 4'd8;
    localparam state_t S_ADDI_EX = 4'd9;
    localparam state_t S_ADDI_WB = 4'd10;
    localparam state_t S_BRANCH  = 4'd11;
    localparam state_t S_JUMP    = 4'd12;
    localparam state_t S_ILLEGAL = 4'd13;

    // ALU operand-B select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Complete set of control outputs produced per cycle
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [5:0] alu_opcode;
        logic [5:0] alu_funct;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    // True for the R-type functions this core executes
    function automatic logic is_rtype_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl_if
//  Description : Controller <-> datapath/memory bundle.
//                master : controller (takes opcode/funct/zero_flag/mem_ready,
//                         drives every control strobe and the retire count)
//                slave  : datapath side (mirror image)
//  Parameters  : CNT_W - width of instr_retired
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero_flag;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [5:0]       alu_opcode;
    logic [5:0]       alu_funct;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  opcode, funct, zero_flag, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_opcode, alu_funct,
               reg_write, reg_dst, mem_to_reg, illegal_op, instr_retired
    );

    modport slave (
        output opcode, funct, zero_flag, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_opcode, alu_funct,
               reg_write, reg_dst, mem_to_reg, illegal_op, instr_retired
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_outdec.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl_outdec
//  Description : Combinational output decoder: current state (+ IR fields,
//                zero_flag, mem_ready) -> control bundle.
//                Ports: state_i, opcode_i, funct_i, zero_flag_i, mem_ready_i
//                       in; ctrl_o (ctrl_t) out.
//  Config      : `MIPS_CTRL_JUMP_EN enables the JUMP state outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl_outdec
    import mips_multicycle_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_flag_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_funct = FN_ADD;     // ALU idles on "add" outside IDLE
        case (state_i)
            S_IDLE: begin
                ctrl_o = '0;
            end
            S_FETCH: begin
                // PC+4 computed while the instruction word is fetched
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut
                ctrl_o.alu_src_b = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.alu_opcode = opcode_i;
            end
            S_MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_funct = funct_i;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.alu_opcode = OP_ADDI;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_REGB;
                ctrl_o.alu_opcode = OP_BEQ;
                ctrl_o.pc_src     = PCSRC_ALUOUT;
                ctrl_o.pc_write   = zero_flag_i;
            end
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
`else
            S_JUMP: begin
                // Unreachable without jump support; keep pc_src off 2'b10
                ctrl_o.pc_src = PCSRC_ALU;
            end
`endif
            S_ILLEGAL: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multi-cycle MIPS control FSM. Holds the state register,
//                next-state logic and the retired-instruction counter;
//                control outputs come from mips_multicycle_ctrl_outdec.
//                Ports: clk, rst_n (sync, active-low),
//                       bus (mips_multicycle_ctrl_if.master).
//  Parameters  : CNT_W - retired-instruction counter width (wraps)
//  Config      : `MIPS_CTRL_JUMP_EN - decode opcode 0x02 as a jump;
//                undefined -> 0x02 is illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] retired_q;
    logic             w_retire;
    ctrl_t            w_ctrl;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: state_d = is_rtype_funct(bus.funct) ? S_EXEC_R : S_ILLEGAL;
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_ADDI:  state_d = S_ADDI_EX;
                    OP_BEQ:   state_d = S_BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
                    OP_J:     state_d = S_JUMP;
`else
                    OP_J:     state_d = S_ILLEGAL;
`endif
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            // Only lw/sw reach MEMADR, so the store test alone picks the path
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    mips_multicycle_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .opcode_i    (bus.opcode),
        .funct_i     (bus.funct),
        .zero_flag_i (bus.zero_flag),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (w_ctrl)
    );

    // ---------------- retire counter ----------------
    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        w_retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_ADDI_WB, S_BRANCH: w_retire = 1'b1;
            S_MEMWR:                               w_retire = bus.mem_ready;
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP:                                w_retire = 1'b1;
`else
            S_JUMP:                                w_retire = 1'b0;
`endif
            default:                               w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (w_retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // ---------------- output mapping ----------------
    assign bus.mem_req       = w_ctrl.mem_req;
    assign bus.mem_write     = w_ctrl.mem_write;
    assign bus.iord          = w_ctrl.iord;
    assign bus.ir_write      = w_ctrl.ir_write;
    assign bus.pc_write      = w_ctrl.pc_write;
    assign bus.pc_src        = w_ctrl.pc_src;
    assign bus.alu_src_a     = w_ctrl.alu_src_a;
    assign bus.alu_src_b     = w_ctrl.alu_src_b;
    assign bus.alu_opcode    = w_ctrl.alu_opcode;
    assign bus.alu_funct     = w_ctrl.alu_funct;
    assign bus.reg_write     = w_ctrl.reg_write;
    assign bus.reg_dst       = w_ctrl.reg_dst;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.illegal_op    = w_ctrl.illegal_op;
    assign bus.instr_retired = retired_q;

endmodule

`default_nettype wire
